// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard control: operand forwarding, load-use and multi-cycle stalls, branch squash.
// Optional macro HAZARD_MEM_FWD_EN enables MEM->EX forwarding; otherwise a MEM match stalls one cycle.
module ex_hazard_ctrl #(
  parameter int unsigned MC_TIMEOUT = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  input  logic [4:0] ex_rs1_addr_i,
  input  logic [4:0] ex_rs2_addr_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic       ex_reg_write_i,
  input  logic       ex_mem_read_i,
  input  logic       ex_valid_i,
  input  logic       ex_mc_req_i,
  input  logic [4:0] mem_rd_addr_i,
  input  logic       mem_reg_write_i,
  input  logic       mem_valid_i,
  input  logic [4:0] wb_rd_addr_i,
  input  logic       wb_reg_write_i,
  input  logic       wb_valid_i,
  input  logic       branch_taken_i,
  input  logic       mc_done_i,
  output logic [1:0] forward_a_o,
  output logic [1:0] forward_b_o,
  output logic       mc_start_o,
  output logic       mc_abort_o,
  output logic       stall_if_o,
  output logic       stall_id_o,
  output logic       stall_ex_o,
  output logic       bubble_ex_o,
  output logic       bubble_mem_o,
  output logic       flush_id_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Value the counter holds during the last BUSY cycle allowed before abort.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MC_TIMEOUT - 1);

  state_e     state_q;
  logic [7:0] cnt_q;

  function automatic logic producer_hit(input logic       valid,
                                        input logic       reg_write,
                                        input logic [4:0] rd,
                                        input logic [4:0] rs);
    return valid & reg_write & (rd != 5'd0) & (rd == rs);
  endfunction

  logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
  logic mem_stall;

  assign mem_hit_a = producer_hit(mem_valid_i, mem_reg_write_i, mem_rd_addr_i, ex_rs1_addr_i);
  assign mem_hit_b = producer_hit(mem_valid_i, mem_reg_write_i, mem_rd_addr_i, ex_rs2_addr_i);
  assign wb_hit_a  = producer_hit(wb_valid_i, wb_reg_write_i, wb_rd_addr_i, ex_rs1_addr_i);
  assign wb_hit_b  = producer_hit(wb_valid_i, wb_reg_write_i, wb_rd_addr_i, ex_rs2_addr_i);

`ifdef HAZARD_MEM_FWD_EN
  assign forward_a_o = mem_hit_a ? FWD_MEM : (wb_hit_a ? FWD_WB : FWD_RF);
  assign forward_b_o = mem_hit_b ? FWD_MEM : (wb_hit_b ? FWD_WB : FWD_RF);
  assign mem_stall   = 1'b0;
`else
  // Without the MEM path, a MEM producer holds EX one cycle until it reaches WB.
  assign forward_a_o = wb_hit_a ? FWD_WB : FWD_RF;
  assign forward_b_o = wb_hit_b ? FWD_WB : FWD_RF;
  assign mem_stall   = mem_hit_a | mem_hit_b;
`endif

  logic load_use;
  assign load_use = ex_valid_i & ex_mem_read_i & (ex_rd_addr_i != 5'd0) &
                    ((id_uses_rs1_i & (ex_rd_addr_i == id_rs1_addr_i)) |
                     (id_uses_rs2_i & (ex_rd_addr_i == id_rs2_addr_i)));

  // IDLE-state decisions in priority order: EX hold, then branch squash, then load-use.
  // The multi-cycle unit samples operands at start, so a pending MEM operand defers launch.
  logic idle_start, idle_hold, idle_flush, idle_lu;
  assign idle_start = ex_valid_i & ex_mc_req_i & ~mem_stall;
  assign idle_hold  = idle_start | mem_stall;
  assign idle_flush = branch_taken_i & ~idle_hold;
  assign idle_lu    = load_use & ~idle_hold & ~idle_flush;

  logic timeout_hit;
  assign timeout_hit = (cnt_q == TIMEOUT_LAST);

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    mc_start_o   = 1'b0;
    mc_abort_o   = 1'b0;
    stall_if_o   = 1'b0;
    stall_id_o   = 1'b0;
    stall_ex_o   = 1'b0;
    bubble_ex_o  = 1'b0;
    bubble_mem_o = 1'b0;
    flush_id_o   = 1'b0;
    case (state_q)
      IDLE: begin
        mc_start_o   = idle_start;
        stall_if_o   = idle_hold | idle_lu;
        stall_id_o   = idle_hold | idle_lu;
        stall_ex_o   = idle_hold;
        bubble_mem_o = idle_hold;
        bubble_ex_o  = idle_flush | idle_lu;
        flush_id_o   = idle_flush;
      end
      BUSY: begin
        if (mc_done_i) begin
          // Result leaves EX this cycle; everything else flows normally.
        end else if (timeout_hit) begin
          mc_abort_o   = 1'b1;
          bubble_mem_o = 1'b1;
        end else begin
          stall_if_o   = 1'b1;
          stall_id_o   = 1'b1;
          stall_ex_o   = 1'b1;
          bubble_mem_o = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (idle_start) begin
            state_q <= BUSY;
            cnt_q   <= 8'd0;
          end
        end
        BUSY: begin
          if (mc_done_i || timeout_hit) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench for ex_hazard_ctrl: directed scenarios plus random traffic against a behavioural model.
`timescale 1ns/1ps
module tb_ex_hazard_ctrl;

  localparam int T = 8;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [4:0] id_rs1_addr_i, id_rs2_addr_i;
  logic       id_uses_rs1_i, id_uses_rs2_i;
  logic [4:0] ex_rs1_addr_i, ex_rs2_addr_i, ex_rd_addr_i;
  logic       ex_reg_write_i, ex_mem_read_i, ex_valid_i, ex_mc_req_i;
  logic [4:0] mem_rd_addr_i;
  logic       mem_reg_write_i, mem_valid_i;
  logic [4:0] wb_rd_addr_i;
  logic       wb_reg_write_i, wb_valid_i;
  logic       branch_taken_i, mc_done_i;
  logic [1:0] forward_a_o, forward_b_o;
  logic       mc_start_o, mc_abort_o;
  logic       stall_if_o, stall_id_o, stall_ex_o;
  logic       bubble_ex_o, bubble_mem_o, flush_id_o;

  ex_hazard_ctrl #(.MC_TIMEOUT(T)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .ex_rs1_addr_i(ex_rs1_addr_i), .ex_rs2_addr_i(ex_rs2_addr_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_reg_write_i(ex_reg_write_i),
    .ex_mem_read_i(ex_mem_read_i), .ex_valid_i(ex_valid_i), .ex_mc_req_i(ex_mc_req_i),
    .mem_rd_addr_i(mem_rd_addr_i), .mem_reg_write_i(mem_reg_write_i), .mem_valid_i(mem_valid_i),
    .wb_rd_addr_i(wb_rd_addr_i), .wb_reg_write_i(wb_reg_write_i), .wb_valid_i(wb_valid_i),
    .branch_taken_i(branch_taken_i), .mc_done_i(mc_done_i),
    .forward_a_o(forward_a_o), .forward_b_o(forward_b_o),
    .mc_start_o(mc_start_o), .mc_abort_o(mc_abort_o),
    .stall_if_o(stall_if_o), .stall_id_o(stall_id_o), .stall_ex_o(stall_ex_o),
    .bubble_ex_o(bubble_ex_o), .bubble_mem_o(bubble_mem_o), .flush_id_o(flush_id_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit       rst;
    bit [4:0] id_rs1, id_rs2;
    bit       id_u1, id_u2;
    bit [4:0] ex_rs1, ex_rs2, ex_rd;
    bit       ex_w, ex_mr, ex_v, ex_mc;
    bit [4:0] mem_rd;
    bit       mem_w, mem_v;
    bit [4:0] wb_rd;
    bit       wb_w, wb_v;
    bit       br, done;
  } stim_t;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic sif, sid, sex, bex, bmem, fid, start, abort;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Model state: whether a multi-cycle op is outstanding and which BUSY cycle comes next (1-based).
  bit m_busy = 1'b0;
  int m_age  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit writes_to(input bit v, input bit w, input bit [4:0] rd, input bit [4:0] rs);
    return v && w && rd != 0 && rd == rs;
  endfunction

  function automatic logic [1:0] ref_fwd(input stim_t s, input bit [4:0] rs);
    bit in_mem = writes_to(s.mem_v, s.mem_w, s.mem_rd, rs);
    bit in_wb  = writes_to(s.wb_v, s.wb_w, s.wb_rd, rs);
`ifdef HAZARD_MEM_FWD_EN
    if (in_mem) return 2'd1;
`endif
    if (in_wb) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit operand_in_mem(input stim_t s);
`ifdef HAZARD_MEM_FWD_EN
    return 1'b0;
`else
    return writes_to(s.mem_v, s.mem_w, s.mem_rd, s.ex_rs1) ||
           writes_to(s.mem_v, s.mem_w, s.mem_rd, s.ex_rs2);
`endif
  endfunction

  task automatic model_step(input stim_t s);
    exp_t e = '0;
    bit   ld_use;
    bit   wait_op;
    bit   launch;
    e.fa = ref_fwd(s, s.ex_rs1);
    e.fb = ref_fwd(s, s.ex_rs2);
    if (s.rst) begin
      m_busy = 1'b0;
      m_age  = 0;
    end
    if (m_busy) begin
      if (s.done) begin
        m_busy = 1'b0;
      end else if (m_age == T) begin
        e.abort = 1; e.bmem = 1;
        m_busy  = 1'b0;
      end else begin
        e.sif = 1; e.sid = 1; e.sex = 1; e.bmem = 1;
        m_age++;
      end
    end else begin
      ld_use  = s.ex_v && s.ex_mr && s.ex_rd != 0 &&
                ((s.id_u1 && s.ex_rd == s.id_rs1) || (s.id_u2 && s.ex_rd == s.id_rs2));
      wait_op = operand_in_mem(s);
      launch  = s.ex_v && s.ex_mc && !wait_op;
      if (launch || wait_op) begin
        e.sif = 1; e.sid = 1; e.sex = 1; e.bmem = 1;
        e.start = launch;
      end else if (s.br) begin
        e.fid = 1; e.bex = 1;
      end else if (ld_use) begin
        e.sif = 1; e.sid = 1; e.bex = 1;
      end
      if (launch && !s.rst) begin
        m_busy = 1'b1;
        m_age  = 1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic apply(input stim_t s);
    rst_i           = s.rst;
    id_rs1_addr_i   = s.id_rs1;  id_rs2_addr_i = s.id_rs2;
    id_uses_rs1_i   = s.id_u1;   id_uses_rs2_i = s.id_u2;
    ex_rs1_addr_i   = s.ex_rs1;  ex_rs2_addr_i = s.ex_rs2;
    ex_rd_addr_i    = s.ex_rd;   ex_reg_write_i = s.ex_w;
    ex_mem_read_i   = s.ex_mr;   ex_valid_i = s.ex_v;  ex_mc_req_i = s.ex_mc;
    mem_rd_addr_i   = s.mem_rd;  mem_reg_write_i = s.mem_w; mem_valid_i = s.mem_v;
    wb_rd_addr_i    = s.wb_rd;   wb_reg_write_i = s.wb_w;   wb_valid_i = s.wb_v;
    branch_taken_i  = s.br;      mc_done_i = s.done;
  endtask

  // Drive one cycle's inputs just after the edge and post its expected response.
  task automatic cycle(input stim_t s);
    @(posedge clk_i);
    #1;
    apply(s);
    model_step(s);
  endtask

  function automatic stim_t quiet();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s        = quiet();
    s.rst    = ($urandom_range(0, 199) == 0);
    if (s.rst) return s;
    s.id_rs1 = 5'($urandom_range(0, 3));  s.id_rs2 = 5'($urandom_range(0, 3));
    s.id_u1  = 1'($urandom);              s.id_u2  = 1'($urandom);
    s.ex_rs1 = 5'($urandom_range(0, 3));  s.ex_rs2 = 5'($urandom_range(0, 3));
    s.ex_rd  = 5'($urandom_range(0, 3));
    s.ex_w   = 1'($urandom);  s.ex_mr = ($urandom_range(0, 2) == 0);
    s.ex_v   = ($urandom_range(0, 3) != 0);
    s.ex_mc  = ($urandom_range(0, 7) == 0);
    s.mem_rd = 5'($urandom_range(0, 3));  s.mem_w = 1'($urandom); s.mem_v = 1'($urandom);
    s.wb_rd  = 5'($urandom_range(0, 3));  s.wb_w  = 1'($urandom); s.wb_v  = 1'($urandom);
    s.br     = ($urandom_range(0, 5) == 0);
    s.done   = ($urandom_range(0, 6) == 0);
    return s;
  endfunction

  // Monitor: outputs are presented every cycle; compare mid-cycle against the oldest expectation.
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("forward_a",  32'(forward_a_o),  32'(e.fa));
      check("forward_b",  32'(forward_b_o),  32'(e.fb));
      check("stall_if",   32'(stall_if_o),   32'(e.sif));
      check("stall_id",   32'(stall_id_o),   32'(e.sid));
      check("stall_ex",   32'(stall_ex_o),   32'(e.sex));
      check("bubble_ex",  32'(bubble_ex_o),  32'(e.bex));
      check("bubble_mem", 32'(bubble_mem_o), 32'(e.bmem));
      check("flush_id",   32'(flush_id_o),   32'(e.fid));
      check("mc_start",   32'(mc_start_o),   32'(e.start));
      check("mc_abort",   32'(mc_abort_o),   32'(e.abort));
    end
  end

  initial begin
    stim_t s;
    apply(quiet());
    #1 rst_i = 1'b1;

    // Reset state with idle inputs.
    s = quiet(); s.rst = 1;
    cycle(s); cycle(s);
    cycle(quiet());

    // Forwarding: MEM and WB both write r5; then the same with rd=0.
    s = quiet();
    s.ex_v = 1; s.ex_rs1 = 5;
    s.mem_v = 1; s.mem_w = 1; s.mem_rd = 5;
    s.wb_v = 1;  s.wb_w = 1;  s.wb_rd = 5;
    cycle(s);
    s.mem_v = 0;
    cycle(s);
    s.mem_v = 1; s.mem_rd = 0; s.wb_rd = 0;
    cycle(s);

    // Load-use on rs2=7, then consumer in EX with the load in WB.
    s = quiet();
    s.ex_v = 1; s.ex_mr = 1; s.ex_w = 1; s.ex_rd = 7;
    s.id_u2 = 1; s.id_rs2 = 7;
    cycle(s);
    s = quiet();
    s.mem_v = 1; s.mem_w = 1; s.mem_rd = 7; s.id_u2 = 1; s.id_rs2 = 7;
    cycle(s);
    s = quiet();
    s.ex_v = 1; s.ex_rs2 = 7; s.wb_v = 1; s.wb_w = 1; s.wb_rd = 7;
    cycle(s);

    // Multi-cycle op with done four cycles after start.
    s = quiet(); s.ex_v = 1; s.ex_mc = 1;
    for (int i = 0; i < 4; i++) cycle(s);
    s.done = 1;
    cycle(s);
    cycle(quiet());

    // Done while idle is ignored.
    s = quiet(); s.done = 1;
    cycle(s);

    // Timeout: done never arrives.
    s = quiet(); s.ex_v = 1; s.ex_mc = 1;
    cycle(s);
    s.ex_mc = 0; s.ex_v = 1;
    for (int i = 0; i < T; i++) cycle(s);
    cycle(quiet());

    // Taken branch with a load-use present.
    s = quiet();
    s.ex_v = 1; s.ex_mr = 1; s.ex_rd = 3; s.id_u1 = 1; s.id_rs1 = 3; s.br = 1;
    cycle(s);

    // Taken branch while BUSY is not honoured.
    s = quiet(); s.ex_v = 1; s.ex_mc = 1;
    cycle(s);
    s.br = 1;
    cycle(s); cycle(s);
    s.br = 0; s.done = 1;
    cycle(s);

    // Reset in the middle of BUSY, then a clean restart.
    s = quiet(); s.ex_v = 1; s.ex_mc = 1;
    cycle(s); cycle(s);
    s = quiet(); s.rst = 1;
    cycle(s);
    s = quiet(); s.ex_v = 1; s.ex_mc = 1;
    cycle(s); cycle(s);
    s.done = 1;
    cycle(s);

    // Random traffic.
    for (int i = 0; i < 4000; i++) cycle(rand_stim());
    cycle(quiet());

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk_i);
    @(negedge clk_i);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
